// File: rtl/leds_s0_arbiter_if.sv
// Avalon-MM bus bundle used for both arbiter masters and the shared s0 slave port.
// The master modport is the side issuing requests; slave is the side answering them.
interface leds_s0_arbiter_if #(
   parameter int DATA_W = 32
) ();
   logic              address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              lock;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata, lock,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, lock,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/leds_s0_arbiter.sv
// Two-master round-robin arbiter for the LED peripheral s0 port, one transaction in flight.
// Define LEDS_ARB_LOCK_EN to let a master keep the grant across transactions via mN_lock.
module leds_s0_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int DATA_W       = 32
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   leds_s0_arbiter_if.slave        m0,
   leds_s0_arbiter_if.slave        m1,
   leds_s0_arbiter_if.master       s0,
   output logic                    grant
);
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

   state_t                   state_reg, state_next;
   logic                     grant_reg, grant_next;
   logic [CNT_W-1:0]         cnt_reg, cnt_next;
   logic [1:0]               waitrequest_reg, waitrequest_next;
   logic [1:0]               readdatavalid_reg, readdatavalid_next;
   logic [1:0][DATA_W-1:0]   readdata_reg, readdata_next;
   logic                     s0_read_reg, s0_read_next;
   logic                     s0_write_reg, s0_write_next;
   logic                     s0_address_reg, s0_address_next;
   logic [DATA_W-1:0]        s0_writedata_reg, s0_writedata_next;

   logic [1:0]               rd, wr, lk, addr, req;
   logic [1:0][DATA_W-1:0]   wdata;
   logic                     rr_pick, rr_valid, pick, pick_valid;
   logic                     unused_sig;

   assign rd       = {m1.read, m0.read};
   assign wr       = {m1.write, m0.write};
   assign lk       = {m1.lock, m0.lock};
   assign addr     = {m1.address, m0.address};
   assign wdata[0] = m0.writedata;
   assign wdata[1] = m1.writedata;
   assign req      = rd | wr;

   assign unused_sig = ^{s0.waitrequest, s0.readdatavalid, lk};

   // On a tie the master that did not win last time gets the slot.
   always_comb begin
      rr_valid = |req;
      rr_pick  = grant_reg;
      case (req)
         2'b01:   rr_pick = 1'b0;
         2'b10:   rr_pick = 1'b1;
         2'b11:   rr_pick = ~grant_reg;
         default: rr_pick = grant_reg;
      endcase
   end

`ifdef LEDS_ARB_LOCK_EN
   logic lock_active_reg, lock_active_next, locked;

   // The lock survives only while its owner is still requesting or still asserting lock.
   assign locked     = lock_active_reg & (req[grant_reg] | lk[grant_reg]);
   assign pick       = locked ? grant_reg : rr_pick;
   assign pick_valid = locked ? req[grant_reg] : rr_valid;

   always_comb begin
      lock_active_next = lock_active_reg;
      if (state_reg == IDLE)
         lock_active_next = pick_valid ? lk[pick] : locked;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         lock_active_reg <= 1'b0;
      else
         lock_active_reg <= lock_active_next;
   end
`else
   assign pick       = rr_pick;
   assign pick_valid = rr_valid;
`endif

   always_comb begin
      state_next         = state_reg;
      grant_next         = grant_reg;
      cnt_next           = cnt_reg;
      readdata_next      = readdata_reg;
      s0_address_next    = s0_address_reg;
      s0_writedata_next  = s0_writedata_reg;
      s0_read_next       = 1'b0;
      s0_write_next      = 1'b0;
      waitrequest_next   = 2'b11;
      readdatavalid_next = 2'b00;

      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               state_next                = ISSUE;
               grant_next                = pick;
               s0_address_next           = addr[pick];
               s0_writedata_next         = wdata[pick];
               s0_write_next             = wr[pick];
               s0_read_next              = rd[pick] & ~wr[pick];
               waitrequest_next[pick]    = 1'b0;
            end
         end
         ISSUE: begin
            if (s0_read_reg) begin
               state_next = RDWAIT;
               cnt_next   = CNT_W'(READ_LATENCY - 1);
            end else begin
               state_next = IDLE;
            end
         end
         RDWAIT: begin
            // Slave data is valid on the edge where the counter has run down.
            if (cnt_reg == '0) begin
               state_next                     = RESP;
               readdata_next[grant_reg]       = s0.readdata;
               readdatavalid_next[grant_reg]  = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg         <= IDLE;
         grant_reg         <= 1'b1;
         cnt_reg           <= '0;
         waitrequest_reg   <= 2'b11;
         readdatavalid_reg <= 2'b00;
         readdata_reg      <= '0;
         s0_read_reg       <= 1'b0;
         s0_write_reg      <= 1'b0;
         s0_address_reg    <= 1'b0;
         s0_writedata_reg  <= '0;
      end else begin
         state_reg         <= state_next;
         grant_reg         <= grant_next;
         cnt_reg           <= cnt_next;
         waitrequest_reg   <= waitrequest_next;
         readdatavalid_reg <= readdatavalid_next;
         readdata_reg      <= readdata_next;
         s0_read_reg       <= s0_read_next;
         s0_write_reg      <= s0_write_next;
         s0_address_reg    <= s0_address_next;
         s0_writedata_reg  <= s0_writedata_next;
      end
   end

   assign m0.waitrequest   = waitrequest_reg[0];
   assign m1.waitrequest   = waitrequest_reg[1];
   assign m0.readdatavalid = readdatavalid_reg[0];
   assign m1.readdatavalid = readdatavalid_reg[1];
   assign m0.readdata      = readdata_reg[0];
   assign m1.readdata      = readdata_reg[1];

   assign s0.read      = s0_read_reg;
   assign s0.write     = s0_write_reg;
   assign s0.address   = s0_address_reg;
   assign s0.writedata = s0_writedata_reg;
   assign s0.lock      = 1'b0;
   assign grant        = grant_reg;
endmodule

// File: tb/tb_leds_s0_arbiter.sv
// Directed bench for leds_s0_arbiter (READ_LATENCY=3); the lock scenario runs when
// LEDS_ARB_LOCK_EN is defined.
module tb_leds_s0_arbiter;
   logic clk_clk = 1'b0;
   logic reset_reset_n;
   logic grant;
   int   checks   = 0;
   int   failures = 0;

   leds_s0_arbiter_if #(.DATA_W(32)) m0_bus ();
   leds_s0_arbiter_if #(.DATA_W(32)) m1_bus ();
   leds_s0_arbiter_if #(.DATA_W(32)) s0_bus ();

   leds_s0_arbiter #(.READ_LATENCY(3), .DATA_W(32)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .m0            (m0_bus),
      .m1            (m1_bus),
      .s0            (s0_bus),
      .grant         (grant)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_checks(input string tag);
      check({tag, "_s0_write"}, 32'(s0_bus.write), 32'd0);
      check({tag, "_s0_read"},  32'(s0_bus.read),  32'd0);
      check({tag, "_m0_wait"},  32'(m0_bus.waitrequest), 32'd1);
      check({tag, "_m1_wait"},  32'(m1_bus.waitrequest), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_reset_n = 1'b0;
      m0_bus.address = 1'b0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
      m0_bus.writedata = '0; m0_bus.lock = 1'b0;
      m1_bus.address = 1'b0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
      m1_bus.writedata = '0; m1_bus.lock = 1'b0;
      s0_bus.waitrequest = 1'b0; s0_bus.readdatavalid = 1'b0;
      s0_bus.readdata = 32'hDEADBEEF;
      step(); step();

      // Reset state
      idle_checks("rst");
      check("rst_m0_rdv",  32'(m0_bus.readdatavalid), 32'd0);
      check("rst_m1_rdv",  32'(m1_bus.readdatavalid), 32'd0);
      check("rst_m0_rdata", m0_bus.readdata, 32'd0);
      check("rst_m1_rdata", m1_bus.readdata, 32'd0);
      check("rst_s0_addr",  32'(s0_bus.address), 32'd0);
      check("rst_s0_wdata", s0_bus.writedata, 32'd0);
      check("rst_grant",    32'(grant), 32'd1);
      reset_reset_n = 1'b1;
      step();

      // m0 write addr 0 data 0xA5
      m0_bus.address = 1'b0; m0_bus.writedata = 32'h000000A5; m0_bus.write = 1'b1;
      step();
      $display("txn m0 write addr=0 data=0x000000a5");
      check("w0_s0_write", 32'(s0_bus.write), 32'd1);
      check("w0_s0_read",  32'(s0_bus.read),  32'd0);
      check("w0_s0_wdata", s0_bus.writedata, 32'h000000A5);
      check("w0_s0_addr",  32'(s0_bus.address), 32'd0);
      check("w0_m0_wait",  32'(m0_bus.waitrequest), 32'd0);
      check("w0_m1_wait",  32'(m1_bus.waitrequest), 32'd1);
      check("w0_grant",    32'(grant), 32'd0);
      step();
      m0_bus.write = 1'b0;
      idle_checks("w0_after");

      // m1 read addr 1, slave data valid only in the latency-3 slot
      m1_bus.address = 1'b1; m1_bus.read = 1'b1;
      step();
      check("r1_s0_read",  32'(s0_bus.read), 32'd1);
      check("r1_s0_addr",  32'(s0_bus.address), 32'd1);
      check("r1_m1_wait",  32'(m1_bus.waitrequest), 32'd0);
      check("r1_grant",    32'(grant), 32'd1);
      step();
      m1_bus.read = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         check($sformatf("r1_norv_%0d", k), 32'(m1_bus.readdatavalid), 32'd0);
         if (k == 4) s0_bus.readdata = 32'h12345678;
         if (k < 4) step();
      end
      step();
      s0_bus.readdata = 32'hDEADBEEF;
      $display("txn m1 read addr=1 data=0x%08h", m1_bus.readdata);
      check("r1_m1_rdv",   32'(m1_bus.readdatavalid), 32'd1);
      check("r1_m1_rdata", m1_bus.readdata, 32'h12345678);
      check("r1_m0_rdv",   32'(m0_bus.readdatavalid), 32'd0);
      check("r1_m0_rdata", m0_bus.readdata, 32'd0);
      check("r1_m0_wait",  32'(m0_bus.waitrequest), 32'd1);
      step();
      check("r1_rdv_once", 32'(m1_bus.readdatavalid), 32'd0);
      check("r1_hold",     m1_bus.readdata, 32'h12345678);

      // Both masters write continuously: m0, m1, m0, m1
      m0_bus.writedata = 32'h11; m0_bus.write = 1'b1;
      m1_bus.writedata = 32'h22; m1_bus.write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         $display("txn rr write %0d grant=%0d data=0x%08h", i, grant, s0_bus.writedata);
         check($sformatf("rr%0d_write", i), 32'(s0_bus.write), 32'd1);
         check($sformatf("rr%0d_wdata", i), s0_bus.writedata, (i % 2 == 0) ? 32'h11 : 32'h22);
         check($sformatf("rr%0d_grant", i), 32'(grant), 32'(i % 2));
         check($sformatf("rr%0d_m0wait", i), 32'(m0_bus.waitrequest), 32'(i % 2));
         check($sformatf("rr%0d_m1wait", i), 32'(m1_bus.waitrequest), 32'((i + 1) % 2));
         step();
         idle_checks($sformatf("rr%0d_gap", i));
      end
      m0_bus.write = 1'b0; m1_bus.write = 1'b0;
      step();
      idle_checks("rr_withdrawn");

      // Read and write together: write wins
      m0_bus.address = 1'b1; m0_bus.writedata = 32'h0F;
      m0_bus.read = 1'b1; m0_bus.write = 1'b1;
      step();
      $display("txn m0 read+write data=0x%08h", s0_bus.writedata);
      check("rw_s0_write", 32'(s0_bus.write), 32'd1);
      check("rw_s0_read",  32'(s0_bus.read),  32'd0);
      check("rw_s0_wdata", s0_bus.writedata, 32'h0F);
      step();
      m0_bus.read = 1'b0; m0_bus.write = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rw_norv_%0d", k), 32'(m0_bus.readdatavalid), 32'd0);
         check($sformatf("rw_nord_%0d", k), 32'(s0_bus.read), 32'd0);
         step();
      end

      // Reset pulsed while a read is in RDWAIT
      m1_bus.address = 1'b0; m1_bus.read = 1'b1;
      step();
      check("rr_rd_issue", 32'(s0_bus.read), 32'd1);
      step();
      m1_bus.read = 1'b0;
      s0_bus.readdata = 32'hCAFEF00D;
      reset_reset_n = 1'b0;
      #1;
      $display("txn reset during m1 read");
      idle_checks("rstmid");
      check("rstmid_grant", 32'(grant), 32'd1);
      check("rstmid_rdata", m1_bus.readdata, 32'd0);
      step();
      reset_reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rstmid_norv_%0d", k), 32'(m1_bus.readdatavalid), 32'd0);
         step();
      end
      m0_bus.address = 1'b0; m0_bus.writedata = 32'h55; m0_bus.write = 1'b1;
      step();
      $display("txn m0 write after reset data=0x%08h", s0_bus.writedata);
      check("post_rst_write", 32'(s0_bus.write), 32'd1);
      check("post_rst_wdata", s0_bus.writedata, 32'h55);
      check("post_rst_grant", 32'(grant), 32'd0);
      step();
      m0_bus.write = 1'b0;

`ifdef LEDS_ARB_LOCK_EN
      // m1 locks for three writes while m0 keeps requesting
      m0_bus.writedata = 32'h44; m0_bus.write = 1'b1;
      m1_bus.writedata = 32'h33; m1_bus.write = 1'b1; m1_bus.lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         $display("txn lock write %0d grant=%0d data=0x%08h", i, grant, s0_bus.writedata);
         check($sformatf("lk%0d_wdata", i), s0_bus.writedata, 32'h33);
         check($sformatf("lk%0d_grant", i), 32'(grant), 32'd1);
         step();
      end
      m1_bus.write = 1'b0; m1_bus.lock = 1'b0;
      begin
         int budget = 6;
         while (budget > 0 && s0_bus.write !== 1'b1) begin
            step();
            budget--;
         end
         check("lk_release_seen", 32'(s0_bus.write), 32'd1);
      end
      $display("txn post-lock write grant=%0d data=0x%08h", grant, s0_bus.writedata);
      check("lk_m0_wdata", s0_bus.writedata, 32'h44);
      check("lk_m0_grant", 32'(grant), 32'd0);
      step();
      m0_bus.write = 1'b0;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/leds_s0_arbiter.md
# leds_s0_arbiter

Two-master Avalon-MM arbiter that shares the custom LED peripheral's s0 slave port between the HPS lightweight bridge (master 0) and a fabric-side pattern sequencer (master 1). It sits between both masters and the slave inside the soc_system fabric. It serialises transactions one at a time with round-robin fairness and converts the slave's fixed read latency into a readdatavalid response for the granted master.

## Interface
Parameters:
- READ_LATENCY, 1: s0 fixed read latency in cycles (1..7).
- DATA_W, 32: data width.

Ports:
- clk_clk  in  1  single fabric clock.
- reset_reset_n  in  1  reset, asynchronous assert, active-low.
- mN_address  in  1  master N word address (N = 0, 1).
- mN_read, mN_write  in  1  master N read and write request.
- mN_writedata  in  DATA_W  master N write data.
- mN_lock  in  1  master N lock request; only used with the lock macro.
- mN_waitrequest  out  1  low for exactly the cycle the request is accepted.
- mN_readdata  out  DATA_W  captured read data, valid with readdatavalid.
- mN_readdatavalid  out  1  one-cycle read response strobe.
- s0_address, s0_read, s0_write  out  1  to slave.
- s0_writedata  out  DATA_W  to slave.
- s0_readdata  in  DATA_W  from slave.
- grant  out  1  index of the current or last granted master (debug).

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE: sample requests (read|write) at the clock edge.
  - Exactly one master requesting: grant it.
  - Both requesting: grant the master that was not granted last (round-robin).
  - No request: remain in IDLE.
  - Go to ISSUE.
- ISSUE, one cycle:
  - Drive s0_* from the granted master's address and writedata.
  - s0_write = mN_write; s0_read = mN_read & ~mN_write.
  - Deassert the granted master's waitrequest.
  - After a write, return to IDLE. After a read, go to RDWAIT with the counter loaded to READ_LATENCY-1.
- RDWAIT: decrement the counter each cycle. When it reaches 0, capture s0_readdata into mN_readdata of the granted master and go to RESP.
- RESP: assert the granted master's readdatavalid for one cycle, then go to IDLE.
- When a master asserts read and write in the same cycle, the write wins and the read is dropped.
- The non-granted master's waitrequest stays high. Its readdata holds its last captured value.
- The s0_* strobes are low in every state except ISSUE. s0_address and s0_writedata hold their last value.

## Timing
- Reset values:
  - mN_waitrequest = 1.
  - mN_readdatavalid = 0, mN_readdata = 0.
  - s0_read = s0_write = 0, s0_address = 0, s0_writedata = 0.
  - grant = 1, so master 0 wins the first tie.
  - FSM in IDLE.
- Write: request sampled at edge E0; s0_write and waitrequest=0 in cycle E0+1. Throughput is 1 write per 2 cycles.
- Read: s0_read in cycle E0+1. Data is captured at edge E0+1+READ_LATENCY. readdatavalid is high in cycle E0+2+READ_LATENCY. IDLE resumes the cycle after.
- Only one transaction is in flight. Requests arriving in ISSUE, RDWAIT or RESP wait for IDLE.
- A master must hold its request until waitrequest goes low. A request that is withdrawn before grant is not issued.
- Reset asserted mid-transaction: all outputs return to reset values immediately. The in-flight read produces no readdatavalid.

## Configuration
- LEDS_ARB_LOCK_EN defined:
  - A master that completes a transaction with mN_lock=1 keeps the grant.
  - IDLE then considers only that master's requests until it completes a transaction with mN_lock=0 or drops lock while idle.
  - Round-robin resumes afterwards.
- LEDS_ARB_LOCK_EN undefined: the mN_lock inputs are ignored and arbitration is pure round-robin.

## Test plan
- Out of reset, m0 writes addr 0 data 0x000000A5 → s0_write=1, s0_writedata=0x000000A5 one cycle after the request; m0_waitrequest low in that same cycle; grant=0.
- READ_LATENCY=3, m1 reads addr 1, slave returns 0x12345678 → m1_readdatavalid high exactly 5 cycles after the request edge; m1_readdata=0x12345678; m0 outputs unchanged.
- m0 and m1 both hold write requests continuously → s0 writes alternate m0, m1, m0, m1 with writedata matching the issuing master; each waitrequest goes low once per 4 cycles.
- LEDS_ARB_LOCK_EN defined, m1 holds lock=1 for 3 writes while m0 requests → three consecutive m1 writes, then m0 is granted next.
- Reset_reset_n pulsed low during RDWAIT → no readdatavalid on either master; s0 strobes 0; the next request after release is granted normally.
- m0 asserts read and write together with data 0x0F → a single s0_write with 0x0F; no s0_read and no readdatavalid.
